// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and data memory.
//   req    : request, held by the master until gnt
//   we     : byte write enables (all zero for loads)
//   addr   : word-aligned address
//   wdata  : lane-replicated store data
//   gnt    : memory accepts the request this cycle
//   rvalid : load data valid on rdata
//   rdata  : read word
// master = load/store unit side, slave = memory side.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit.
// Accepts an effective address and store data from the execute stage, runs
// one req/gnt(/rvalid) transaction on the data-memory bus and returns an
// extended load result.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : request strobe, only sampled while idle
//   is_store     : 1 = store, 0 = load
//   funct3       : RV32I width/sign code (B, H, W, BU, HU)
//   addr, wdata  : effective address and store data (rs2)
//   busy         : high whenever a transaction is in progress
//   done, fault  : one-cycle completion pulse, fault marks a rejected access
//   rdata        : extended load result, held until the next accepted start
//   dmem         : data-memory bus (master side)
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [31:0]          wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [31:0]          rdata,
    load_store_unit_if.master    dmem
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t            state_r;
    logic              busy_r;
    logic              done_r;
    logic              fault_r;
    logic [31:0]       rdata_r;
    logic              is_store_r;
    logic [2:0]        funct3_r;
    logic [1:0]        offset_r;
    logic              dmem_req_r;
    logic [3:0]        dmem_we_r;
    logic [ADDR_W-1:0] dmem_addr_r;
    logic [31:0]       dmem_wdata_r;
    logic              fault_s;

    // Rejects illegal width codes and misaligned halfword/word accesses.
    function automatic logic access_fault(input logic st, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic bad_f3;
        logic misaligned;
        if (st) begin
            bad_f3 = (f3 > 3'b010);
        end else begin
            bad_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        end
        misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                     ((f3 == 3'b010) && (off != 2'b00));
        return bad_f3 || misaligned;
    endfunction

    // Byte enables for a store of the given width at byte offset off.
    function automatic logic [3:0] lane_we(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] we;
        case (f3[1:0])
            2'b00:   we = 4'b0001 << off;
            2'b01:   we = 4'b0011 << off;
            2'b10:   we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

    // Replicate narrow store data across all lanes so any byte enable picks it up.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{w[7:0]}};
            2'b01:   r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] r;
        shifted = word >> {off, 3'b000};
        half    = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  r = {24'h000000, shifted[7:0]};
            3'b001:  r = {{16{half[15]}}, half};
            3'b101:  r = {16'h0000, half};
            default: r = word;
        endcase
        return r;
    endfunction

    assign fault_s = access_fault(is_store, funct3, addr[1:0]);

    // Transaction FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
            rdata_r      <= 32'h0000_0000;
            is_store_r   <= 1'b0;
            funct3_r     <= 3'b000;
            offset_r     <= 2'b00;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 4'b0000;
            dmem_addr_r  <= '0;
            dmem_wdata_r <= 32'h0000_0000;
        end else begin
            done_r  <= 1'b0;
            fault_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        is_store_r <= is_store;
                        funct3_r   <= funct3;
                        offset_r   <= addr[1:0];
                        rdata_r    <= 32'h0000_0000;
                        busy_r     <= 1'b1;
                        if (fault_s) begin
                            state_r <= ST_ERR;
                            done_r  <= 1'b1;
                            fault_r <= 1'b1;
                        end else begin
                            state_r      <= ST_REQ;
                            dmem_req_r   <= 1'b1;
                            dmem_addr_r  <= {addr[ADDR_W-1:2], 2'b00};
                            dmem_we_r    <= is_store ? lane_we(funct3, addr[1:0]) : 4'b0000;
                            dmem_wdata_r <= is_store ? lane_wdata(funct3, wdata) : 32'h0000_0000;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem.gnt) begin
                        dmem_req_r <= 1'b0;
                        // Drop enables with the request so no stray write is visible.
                        dmem_we_r  <= 4'b0000;
                        if (is_store_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem.rvalid) begin
                        rdata_r <= load_extract(funct3_r, offset_r, dmem.rdata);
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    dmem_req_r <= 1'b0;
                    dmem_we_r  <= 4'b0000;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign fault      = fault_r;
    assign rdata      = rdata_r;
    assign dmem.req   = dmem_req_r;
    assign dmem.we    = dmem_we_r;
    assign dmem.addr  = dmem_addr_r;
    assign dmem.wdata = dmem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table run through a bus
// responder with programmable grant/rvalid delays, plus hand sequences for
// reset mid-load, start during busy and start held across done.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;

    load_store_unit_if #(.ADDR_W(32)) dmem_bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .is_store (is_store),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .fault    (fault),
        .rdata    (rdata),
        .dmem     (dmem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic        flt;
        logic [3:0]  we;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v, input int gdly, input int rdly,
                       input bit glitch, input string tag);
        int          req_n;
        int          done_n;
        int          done_c;
        int          gnt_c;
        int          stable_err;
        int          exp_c;
        logic        fault_seen;
        logic        busy_after;
        logic [31:0] rd_seen;
        logic [31:0] a0;
        logic [3:0]  we0;
        logic [31:0] wd0;
        req_n = 0; done_n = 0; done_c = -1; gnt_c = -1; stable_err = 0;
        fault_seen = 1'b0; busy_after = 1'b1; rd_seen = 32'h0;
        a0 = 32'h0; we0 = 4'h0; wd0 = 32'h0;
        start = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = v.mem;
        tick();
        start = 1'b0;
        if (glitch) begin
            start = 1'b1; is_store = ~v.st; funct3 = 3'b010;
            addr = 32'hFFFF_FFF0; wdata = 32'h0;
        end
        for (int c = 1; c < 40; c++) begin
            if (glitch && c == 2) start = 1'b0;
            dmem_bus.gnt = 1'b0;
            dmem_bus.rvalid = 1'b0;
            if (dmem_bus.req) begin
                if (req_n == 0) begin
                    a0 = dmem_bus.addr; we0 = dmem_bus.we; wd0 = dmem_bus.wdata;
                end else if (dmem_bus.addr !== a0 || dmem_bus.we !== we0 ||
                             dmem_bus.wdata !== wd0) begin
                    stable_err++;
                end
                if (req_n == gdly) begin
                    dmem_bus.gnt = 1'b1;
                    gnt_c = c;
                end
                req_n++;
            end
            if (!v.st && gnt_c >= 0 && c == gnt_c + rdly) dmem_bus.rvalid = 1'b1;
            if (done) begin
                done_n++;
                if (done_c < 0) begin
                    done_c = c; fault_seen = fault; rd_seen = rdata;
                end
            end
            if (done_c >= 0 && c == done_c + 1) begin
                busy_after = busy;
                break;
            end
            tick();
        end
        dmem_bus.gnt = 1'b0;
        dmem_bus.rvalid = 1'b0;
        exp_c = v.flt ? 1 : (v.st ? 2 + gdly : 2 + gdly + rdly);
        chk(tag, "done_cycle", done_c, exp_c);
        chk(tag, "done_count", done_n, 1);
        chk(tag, "fault", {31'h0, fault_seen}, {31'h0, v.flt});
        chk(tag, "rdata", rd_seen, v.erd);
        chk(tag, "req_cycles", req_n, v.flt ? 0 : gdly + 1);
        chk(tag, "busy_after_done", {31'h0, busy_after}, 32'h0);
        if (!v.flt) begin
            chk(tag, "dmem_addr", a0, {v.addr[31:2], 2'b00});
            chk(tag, "dmem_we", {28'h0, we0}, {28'h0, v.we});
            if (v.st) chk(tag, "dmem_wdata", wd0, v.ewd);
            chk(tag, "req_stable", stable_err, 0);
        end
    endtask

    initial begin
        int done_seen;
        vec_t v;
        //            st    f3      addr          wdata         mem           flt   we       ewd           erd
        vecs[0]  = '{1'b1, 3'b000, 32'h0000_1002, 32'h0000_00A5, 32'h0,        1'b0, 4'b0100, 32'hA5A5_A5A5, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_2003, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_2003, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'h0000_80FF};
        vecs[4]  = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'hFFFF_80FF};
        vecs[5]  = '{1'b0, 3'b010, 32'h0000_2000, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'h80FF_1234};
        vecs[6]  = '{1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0,        1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[7]  = '{1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[8]  = '{1'b0, 3'b000, 32'h0000_2001, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'h0000_0012};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_3002, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 3'b101, 32'h0000_2000, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'h0000_1234};
        vecs[11] = '{1'b1, 3'b001, 32'h0000_3001, 32'h0000_5555, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 3'b000, 32'h0000_1001, 32'h0000_005A, 32'h0,        1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0};
        vecs[13] = '{1'b0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[14] = '{1'b1, 3'b100, 32'h0000_3000, 32'h0,        32'h0,         1'b1, 4'b0000, 32'h0,        32'h0};

        reset_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0;
        dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'h0;
        tick(); tick();
        chk("reset", "busy", {31'h0, busy}, 32'h0);
        chk("reset", "done", {31'h0, done}, 32'h0);
        chk("reset", "fault", {31'h0, fault}, 32'h0);
        chk("reset", "rdata", rdata, 32'h0);
        chk("reset", "dmem_req", {31'h0, dmem_bus.req}, 32'h0);
        chk("reset", "dmem_we", {28'h0, dmem_bus.we}, 32'h0);
        chk("reset", "dmem_addr", dmem_bus.addr, 32'h0);
        chk("reset", "dmem_wdata", dmem_bus.wdata, 32'h0);
        reset_n = 1'b1;
        tick();

        // Zero-wait memory: gnt in the first REQ cycle, rvalid the next cycle.
        for (int i = 0; i < 15; i++) begin
            run(vecs[i], 0, 1, 1'b0, $sformatf("vec%0d", i));
            tick();
        end

        // Slow memory: gnt after 3 extra REQ cycles, rvalid 2 cycles after gnt.
        v = '{1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hCAFE_0123, 1'b0, 4'b0000, 32'h0, 32'hCAFE_0123};
        run(v, 3, 2, 1'b0, "slow_lw");
        tick();

        // start pulsed while busy must not disturb or queue anything.
        v = '{1'b1, 3'b010, 32'h0000_1008, 32'h0BAD_F00D, 32'h0, 1'b0, 4'b1111, 32'h0BAD_F00D, 32'h0};
        run(v, 2, 1, 1'b1, "busy_start");
        tick();

        // Reset asserted while waiting for load data.
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_3000;
        dmem_bus.rdata = 32'h1357_9BDF;
        tick();
        start = 1'b0; dmem_bus.gnt = 1'b1;
        tick();
        dmem_bus.gnt = 1'b0;
        chk("rst_mid", "busy_in_wait", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid", "busy", {31'h0, busy}, 32'h0);
        chk("rst_mid", "dmem_req", {31'h0, dmem_bus.req}, 32'h0);
        chk("rst_mid", "done", {31'h0, done}, 32'h0);
        chk("rst_mid", "rdata", rdata, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        dmem_bus.rvalid = 1'b1;
        tick();
        dmem_bus.rvalid = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) done_seen++;
            tick();
        end
        chk("rst_mid", "late_rvalid_done", done_seen, 0);
        chk("rst_mid", "late_rvalid_rdata", rdata, 32'h0);

        // start held high across done: the next start is taken in the idle cycle after done.
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h0000_1000; wdata = 32'h0000_0011;
        dmem_bus.gnt = 1'b1;
        tick();
        chk("held", "c1_req", {31'h0, dmem_bus.req}, 32'h1);
        tick();
        chk("held", "c2_done", {31'h0, done}, 32'h1);
        tick();
        chk("held", "c3_busy", {31'h0, busy}, 32'h0);
        chk("held", "c3_req", {31'h0, dmem_bus.req}, 32'h0);
        tick();
        chk("held", "c4_req", {31'h0, dmem_bus.req}, 32'h1);
        chk("held", "c4_busy", {31'h0, busy}, 32'h1);
        start = 1'b0;
        tick();
        chk("held", "c5_done", {31'h0, done}, 32'h1);
        tick();
        chk("held", "c6_done", {31'h0, done}, 32'h0);
        dmem_bus.gnt = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
